// File: rtl/tag_issue_sched.sv
// tag_issue_sched: takes one job descriptor and loads its tags into the column tag allocator one at a time.
// Optional per-job stall counter output is enabled by defining TAG_ISSUE_SCHED_STALL_CNT_EN.
module tag_issue_sched #(
  parameter int NUM_COL = 8,
  parameter int TW      = $clog2(NUM_COL) + 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_kernel_size,
  input  logic [CNT_W-1:0] cfg_num_tags,
  input  logic [TW-1:0]    cfg_first_tag,
  input  logic             abort,
  input  logic             tag_busy,
  output logic             flush_tag,
  output logic [TW-1:0]    tag_in,
  output logic [7:0]       kernel_size,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] issued_cnt
`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;

  localparam logic [7:0] NUM_COL_K = 8'(NUM_COL);

  state_t           state_q, state_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             flush_tag_q, flush_tag_d;
  logic [TW-1:0]    tag_in_q, tag_in_d;
  logic [7:0]       kernel_size_q, kernel_size_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TW-1:0]    next_tag_q, next_tag_d;
  logic [7:0]       gap_q, gap_d;

  logic             cfg_fire;
  logic             cfg_bad;
  logic             job_accept;
  logic [TW-1:0]    first_tag;
  logic [7:0]       gap_load;
  logic [TW-1:0]    issue_tag;
  logic [CNT_W-1:0] issue_rem;
  logic [CNT_W-1:0] issue_cnt;

  // Tag 0 is reserved by the allocator, so the sequence wraps from all-ones back to 1.
  function automatic logic [TW-1:0] tag_advance(input logic [TW-1:0] t);
    if (t == {TW{1'b1}}) begin
      return TW'(1);
    end
    return t + TW'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    cfg_ready_d   = 1'b0;
    flush_tag_d   = 1'b0;
    tag_in_d      = tag_in_q;
    kernel_size_d = kernel_size_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    issued_cnt_d  = issued_cnt_q;
    remaining_d   = remaining_q;
    next_tag_d    = next_tag_q;
    gap_d         = gap_q;
    job_accept    = 1'b0;

    cfg_fire  = cfg_valid && cfg_ready_q && !abort;
    cfg_bad   = (cfg_kernel_size == 8'd0) || (cfg_kernel_size > NUM_COL_K) ||
                (cfg_num_tags == '0);
    first_tag = (cfg_first_tag == '0) ? TW'(1) : cfg_first_tag;
    // The gap never drops below two cycles so the allocator's registered tag_busy is valid in WAIT.
    gap_load  = (kernel_size_q < 8'd2) ? 8'd1 : kernel_size_q - 8'd1;

    issue_tag = next_tag_q;
    issue_rem = remaining_q;
    issue_cnt = issued_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            job_accept    = 1'b1;
            state_d       = ISSUE;
            kernel_size_d = cfg_kernel_size;
            issue_tag     = first_tag;
            issue_rem     = cfg_num_tags;
            issue_cnt     = '0;
          end
        end
      end
      ISSUE: begin
        gap_d   = gap_load;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = WAIT;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      WAIT: begin
        if (!tag_busy) begin
          state_d = (remaining_q != '0) ? ISSUE : DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // Outputs are registered against the state being entered, so they line up with that state.
    if (state_d == ISSUE) begin
      flush_tag_d  = 1'b1;
      tag_in_d     = issue_tag;
      next_tag_d   = tag_advance(issue_tag);
      remaining_d  = issue_rem - CNT_W'(1);
      issued_cnt_d = issue_cnt + CNT_W'(1);
    end

    busy_d      = (state_d == ISSUE) || (state_d == GAP) || (state_d == WAIT);
    done_d      = (state_d == DONE);
    cfg_ready_d = (state_d == IDLE) && !(abort && (state_q == IDLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_ready_q   <= 1'b0;
      flush_tag_q   <= 1'b0;
      tag_in_q      <= '0;
      kernel_size_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      issued_cnt_q  <= '0;
      remaining_q   <= '0;
      next_tag_q    <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      cfg_ready_q   <= cfg_ready_d;
      flush_tag_q   <= flush_tag_d;
      tag_in_q      <= tag_in_d;
      kernel_size_q <= kernel_size_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      issued_cnt_q  <= issued_cnt_d;
      remaining_q   <= remaining_d;
      next_tag_q    <= next_tag_d;
      gap_q         <= gap_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign flush_tag   = flush_tag_q;
  assign tag_in      = tag_in_q;
  assign kernel_size = kernel_size_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign issued_cnt  = issued_cnt_q;

`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (job_accept) begin
      stall_d = '0;
    end else if ((state_q == WAIT) && tag_busy && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tag_issue_sched.sv
// Scoreboard bench for tag_issue_sched: a driver queues expected flushes/done/err pulses, a monitor checks them.
module tb_tag_issue_sched;
  localparam int NUM_COL = 8;
  localparam int TW      = $clog2(NUM_COL) + 1;
  localparam int CNT_W   = 16;
  localparam int TAG_MOD = (1 << TW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [7:0]       cfg_kernel_size = '0;
  logic [CNT_W-1:0] cfg_num_tags = '0;
  logic [TW-1:0]    cfg_first_tag = '0;
  logic             abort = 1'b0;
  logic             tag_busy = 1'b0;
  logic             flush_tag;
  logic [TW-1:0]    tag_in;
  logic [7:0]       kernel_size;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] issued_cnt;
`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  always #5 clk = ~clk;

  tag_issue_sched #(.NUM_COL(NUM_COL), .TW(TW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_size(cfg_kernel_size), .cfg_num_tags(cfg_num_tags),
    .cfg_first_tag(cfg_first_tag), .abort(abort), .tag_busy(tag_busy),
    .flush_tag(flush_tag), .tag_in(tag_in), .kernel_size(kernel_size),
    .busy(busy), .done(done), .cfg_err(cfg_err), .issued_cnt(issued_cnt)
`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct { int tag; int gap; bit exact; } fl_exp_t;
  typedef struct { int cnt; int gap; bit exact; } dn_exp_t;

  fl_exp_t fl_q[$];
  dn_exp_t dn_q[$];
  int      err_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int last_flush = 0;
  bit rand_busy = 1'b0;
  bit busy_force = 1'b0;
  int last_k = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // tag_busy is updated 2ns after each edge from either the random source or the directed level.
  always @(posedge clk) begin
    #2;
    tag_busy = rand_busy ? ($urandom_range(0, 3) == 0) : busy_force;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic check_min(input string name, input longint act, input longint lo);
    n_checks++;
    if (act < lo) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, lo, cycle);
    end
  endtask

  // Reference: the i-th tag of a job is the first tag (0 read as 1) stepped i times through 1..2^TW-1.
  function automatic int tag_at(input int f, input int i);
    int base;
    base = (f == 0) ? 1 : f;
    return ((base - 1 + i) % TAG_MOD) + 1;
  endfunction

  function automatic int spacing(input int k);
    return ((k < 2) ? 2 : k) + 1;
  endfunction

  task automatic push_job(input int k, input int n, input int f, input int upto,
                          input bit exact, input bit with_done);
    fl_exp_t fe;
    dn_exp_t de;
    for (int i = 0; i < upto; i++) begin
      fe.tag = tag_at(f, i);
      fe.gap = (i == 0) ? 0 : spacing(k);
      fe.exact = exact;
      fl_q.push_back(fe);
    end
    if (with_done) begin
      de.cnt = n;
      de.gap = spacing(k);
      de.exact = exact;
      dn_q.push_back(de);
    end
  endtask

  // Monitor: every DUT output event is matched against the head of its expectation queue.
  always @(negedge clk) begin
    fl_exp_t fe;
    dn_exp_t de;
    int ek;
    if (!rst) begin
      if (flush_tag) begin
        if (fl_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_flush: tag_in=%0d, expected no flush (cycle %0d)", tag_in, cycle);
        end else begin
          fe = fl_q.pop_front();
          check("flush_tag_value", tag_in, fe.tag);
          if (fe.gap > 0) begin
            if (fe.exact) check("flush_spacing", cycle - last_flush, fe.gap);
            else          check_min("flush_spacing_min", cycle - last_flush, fe.gap);
          end
        end
        last_flush = cycle;
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: issued_cnt=%0d, expected no done (cycle %0d)", issued_cnt, cycle);
        end else begin
          de = dn_q.pop_front();
          check("done_issued_cnt", issued_cnt, de.cnt);
          check("done_busy_low", busy, 0);
          if (de.exact) check("done_spacing", cycle - last_flush, de.gap);
          else          check_min("done_spacing_min", cycle - last_flush, de.gap);
        end
      end
      if (cfg_err) begin
        if (err_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cfg_err: got 1, expected 0 (cycle %0d)", cycle);
        end else begin
          ek = err_q.pop_front();
          check("cfg_err_kernel_held", kernel_size, ek);
          check("cfg_err_busy_low", busy, 0);
        end
      end
    end
  end

  task automatic send_cfg(input int k, input int n, input int f);
    int t;
    t = 0;
    while (!cfg_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!cfg_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cfg_ready_timeout: got 0, expected 1 (cycle %0d)", cycle);
    end
    cfg_kernel_size = 8'(k);
    cfg_num_tags    = CNT_W'(n);
    cfg_first_tag   = TW'(f);
    cfg_valid       = 1'b1;
    @(posedge clk); #1;
    cfg_valid       = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got 0, expected 1 (cycle %0d)", cycle);
    end
  endtask

  task automatic wait_flush(input int cnt);
    int seen;
    int t;
    seen = flush_tag ? 1 : 0;
    t = 0;
    while (seen < cnt && t < 500) begin
      @(posedge clk); #1; t++;
      if (flush_tag) seen++;
    end
    if (seen < cnt) begin
      n_checks++; n_fail++;
      $display("FAIL flush_timeout: got %0d flushes, expected %0d (cycle %0d)", seen, cnt, cycle);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_flush_tag"}, flush_tag, 0);
    check({tag, "_tag_in"}, tag_in, 0);
    check({tag, "_kernel_size"}, kernel_size, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_issued_cnt"}, issued_cnt, 0);
`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, f, kind;
    bit rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", cfg_ready, 1);

    // Basic job: tags 5..8, spacing 4
    push_job(3, 4, 5, 4, 1'b1, 1'b1);
    send_cfg(3, 4, 5);
    wait_done();
    check("basic_issued_cnt", issued_cnt, 4);
    check("basic_kernel_size", kernel_size, 3);
    @(posedge clk); #1;
    check("basic_ready_back", cfg_ready, 1);
    check("basic_busy_low", busy, 0);

    // First tag 0 maps to 1; wrap 14, 15, 1
    push_job(2, 2, 0, 2, 1'b1, 1'b1);
    send_cfg(2, 2, 0);
    wait_done();
    push_job(4, 3, 14, 3, 1'b1, 1'b1);
    send_cfg(4, 3, 14);
    wait_done();
    check("wrap_issued_cnt", issued_cnt, 3);

    // Busy stall: kernel 1, tag_busy high for 10 WAIT cycles after the first gap
    begin
      fl_exp_t fe;
      dn_exp_t de;
      fe.tag = 1; fe.gap = 0; fe.exact = 1'b1; fl_q.push_back(fe);
      fe.tag = 2; fe.gap = spacing(1) + 10; fe.exact = 1'b1; fl_q.push_back(fe);
      de.cnt = 2; de.gap = spacing(1); de.exact = 1'b1; dn_q.push_back(de);
    end
    send_cfg(1, 2, 1);
    wait_flush(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    busy_force = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    busy_force = 1'b0;
    wait_done();
`ifdef TAG_ISSUE_SCHED_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 10);
`endif
    last_k = 1;

    // Rejected descriptors
    for (int i = 0; i < 3; i++) begin
      err_q.push_back(last_k);
      if (i == 0)      send_cfg(0, 2, 1);
      else if (i == 1) send_cfg(9, 2, 1);
      else             send_cfg(3, 0, 1);
      @(posedge clk); #1;
      check("err_ready_stays", cfg_ready, 1);
      check("err_busy_stays", busy, 0);
    end
    check("err_issued_unchanged", issued_cnt, 2);

    // Abort in the gap after the 2nd of 5 tags
    push_job(3, 5, 3, 2, 1'b1, 1'b0);
    send_cfg(3, 5, 3);
    wait_flush(2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", cfg_ready, 1);
    check("abort_done", done, 0);
    check("abort_issued_cnt", issued_cnt, 2);
    repeat (20) @(posedge clk);
    #1;
    last_k = 3;

    // Abort held with a valid descriptor in IDLE blocks acceptance
    abort = 1'b1;
    cfg_kernel_size = 8'd2; cfg_num_tags = CNT_W'(1); cfg_first_tag = TW'(1);
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_idle_ready", cfg_ready, 0);
      check("abort_idle_busy", busy, 0);
    end
    abort = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_ready_back", cfg_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // Randomised jobs, some rejected, some with random tag_busy
    for (int j = 0; j < 16; j++) begin
      kind = $urandom_range(0, 4);
      f = $urandom_range(0, TAG_MOD);
      if (kind == 0) begin
        k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(NUM_COL + 1, 255);
        err_q.push_back(last_k);
        send_cfg(k, $urandom_range(1, 4), f);
        repeat (2) @(posedge clk);
        #1;
      end else begin
        k = $urandom_range(1, NUM_COL);
        n = $urandom_range(1, 6);
        rb = $urandom_range(0, 1);
        rand_busy = rb;
        push_job(k, n, f, n, !rb, 1'b1);
        send_cfg(k, n, f);
        wait_done();
        rand_busy = 1'b0;
        last_k = k;
      end
    end

    // Reset while waiting on tag_busy
    push_job(2, 4, 7, 1, 1'b1, 1'b0);
    send_cfg(2, 4, 7);
    wait_flush(1);
    busy_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midjob_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    busy_force = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midjob_reset", cfg_ready, 1);
    push_job(2, 2, 7, 2, 1'b1, 1'b1);
    send_cfg(2, 2, 7);
    wait_done();
    repeat (5) @(posedge clk);
    #1;

    check("pending_flush_expectations", fl_q.size(), 0);
    check("pending_done_expectations", dn_q.size(), 0);
    check("pending_err_expectations", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
